// File: rtl/blake2_io_stream.sv
// BLAKE2 I/O stream front end: configuration capture, block assembly with a
// ready handshake toward the compression core, and digest serialisation.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for CONF or START; DATA/LAST are accepted and dropped
// S_FILL  | assembling message bytes into the current block
// S_HOLD  | block presented to the core, waiting for block_ready_i
// S_HWAIT | last block consumed, waiting for the digest pulse
// S_HOUT  | streaming the digest out, one beat per cycle
module blake2_io_stream #(
    parameter int DW_B   = 1,
    parameter int BB     = 64,
    parameter int LL_W   = 64,
    parameter int HASH_B = 32
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [1:0]               cmd_i,
    input  logic [8*DW_B-1:0]        data_i,
    output logic [7:0]               kk_o,
    output logic [7:0]               nn_o,
    output logic [LL_W-1:0]          ll_o,
    output logic                     block_v_o,
    input  logic                     block_ready_i,
    output logic [8*BB-1:0]          block_o,
    output logic                     block_first_o,
    output logic                     block_last_o,
    output logic [$clog2(BB+1)-1:0]  block_bytes_o,
    input  logic                     hash_v_i,
    input  logic [8*HASH_B-1:0]      hash_i,
    output logic                     hash_v_o,
    output logic [8*DW_B-1:0]        hash_o,
    output logic                     hash_last_o
);

    localparam int IW      = $clog2(BB + 1);
    localparam int CFG_MAX = 2 + LL_W / 8;
    localparam int CW      = $clog2(CFG_MAX + 1);
    localparam int RW      = $clog2(HASH_B + 1);

    localparam logic [1:0] CMD_CONF  = 2'd0;
    localparam logic [1:0] CMD_START = 2'd1;
    localparam logic [1:0] CMD_LAST  = 2'd3;

    localparam logic [8*BB-1:0] W_LANE_MASK = {{(8*BB-8*DW_B){1'b0}}, {(8*DW_B){1'b1}}};

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_HOLD, S_HWAIT, S_HOUT} state_t;

    state_t              r_state, w_state_nx;
    logic [7:0]          r_kk, r_nn, w_kk_nx, w_nn_nx;
    logic [LL_W-1:0]     r_ll, w_ll_nx;
    logic [CW-1:0]       r_cfg_cnt, w_cfg_cnt_nx;
    logic [8*BB-1:0]     r_buf, w_buf_base, w_buf_wr, w_beat_ext;
    logic [IW-1:0]       r_idx, w_base, w_idx_wr;
    logic                r_first, r_last;
    logic [8*HASH_B-1:0] r_hash;
    logic [RW-1:0]       r_rem, w_hlen;
    logic                w_acc, w_wr_en, w_close, w_release, w_cap, w_hout_end;

    assign ready_o       = (r_state == S_IDLE) || (r_state == S_FILL);
    assign w_acc         = valid_i & ready_o;
    assign block_v_o     = (r_state == S_HOLD);
    assign block_o       = r_buf;
    assign block_first_o = r_first;
    assign block_last_o  = r_last;
    assign block_bytes_o = r_idx;
    assign kk_o          = r_kk;
    assign nn_o          = r_nn;
    assign ll_o          = r_ll;
    assign hash_v_o      = (r_state == S_HOUT);
    assign w_hout_end    = (r_state == S_HOUT) && (r_rem <= RW'(DW_B));
    assign hash_last_o   = w_hout_end;
    assign w_beat_ext    = {{(8*BB-8*DW_B){1'b0}}, data_i};
    assign w_hlen        = (r_nn >= 8'd1 && r_nn <= 8'(HASH_B)) ? RW'(r_nn) : RW'(HASH_B);

    // Walk the beat lanes in order through the saturating config byte counter
    always_comb begin
        w_kk_nx      = r_kk;
        w_nn_nx      = r_nn;
        w_ll_nx      = r_ll;
        w_cfg_cnt_nx = r_cfg_cnt;
        for (int j = 0; j < DW_B; j++) begin
            if (w_cfg_cnt_nx == CW'(0))
                w_kk_nx = data_i[8*j +: 8];
            else if (w_cfg_cnt_nx == CW'(1))
                w_nn_nx = data_i[8*j +: 8];
            else if (w_cfg_cnt_nx < CW'(CFG_MAX))
                w_ll_nx = {w_ll_nx[LL_W-9:0], data_i[8*j +: 8]};
            if (w_cfg_cnt_nx < CW'(CFG_MAX))
                w_cfg_cnt_nx = w_cfg_cnt_nx + CW'(1);
        end
    end

    // Block buffer after writing the current beat; START writes into a cleared buffer at 0
    always_comb begin
        w_base     = (cmd_i == CMD_START) ? '0 : r_idx;
        w_buf_base = (cmd_i == CMD_START) ? '0 : r_buf;
        w_buf_wr   = (w_buf_base & ~(W_LANE_MASK << {w_base, 3'b000}))
                   | (w_beat_ext << {w_base, 3'b000});
        w_idx_wr   = w_base + IW'(DW_B);
    end

    // Next-state logic and datapath strobes
    always_comb begin
        w_state_nx = r_state;
        w_wr_en    = 1'b0;
        w_close    = 1'b0;
        w_release  = 1'b0;
        w_cap      = 1'b0;
        case (r_state)
            S_IDLE, S_FILL: begin
                if (w_acc && (cmd_i == CMD_START || (r_state == S_FILL && cmd_i != CMD_CONF))) begin
                    w_wr_en    = 1'b1;
                    w_close    = (w_idx_wr == IW'(BB)) || (cmd_i == CMD_LAST);
                    w_state_nx = w_close ? S_HOLD : S_FILL;
                end
            end
            S_HOLD: begin
                if (block_ready_i) begin
                    w_release  = 1'b1;
                    w_state_nx = r_last ? S_HWAIT : S_FILL;
                end
            end
            S_HWAIT: begin
                if (hash_v_i) begin
                    w_cap      = 1'b1;
                    w_state_nx = S_HOUT;
                end
            end
            S_HOUT: begin
                if (w_hout_end)
                    w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nx;
    end

    // Config registers, block buffer and digest shifter
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_kk      <= '0;
            r_nn      <= '0;
            r_ll      <= '0;
            r_cfg_cnt <= '0;
            r_buf     <= '0;
            r_idx     <= '0;
            r_first   <= 1'b0;
            r_last    <= 1'b0;
            r_hash    <= '0;
            r_rem     <= '0;
        end else begin
            if (w_acc) begin
                if (cmd_i == CMD_CONF) begin
                    r_kk      <= w_kk_nx;
                    r_nn      <= w_nn_nx;
                    r_ll      <= w_ll_nx;
                    r_cfg_cnt <= w_cfg_cnt_nx;
                end else begin
                    r_cfg_cnt <= '0;
                end
            end
            if (w_wr_en) begin
                r_buf  <= w_buf_wr;
                r_idx  <= w_idx_wr;
                r_last <= (cmd_i == CMD_LAST);
                if (cmd_i == CMD_START)
                    r_first <= 1'b1;
            end
            if (w_release) begin
                r_first <= 1'b0;
                if (!r_last) begin
                    r_buf <= '0;
                    r_idx <= '0;
                end
            end
            if (w_cap) begin
                r_hash <= hash_i;
                r_rem  <= w_hlen;
            end else if (r_state == S_HOUT) begin
                r_hash <= r_hash >> (8 * DW_B);
                r_rem  <= w_hout_end ? '0 : r_rem - RW'(DW_B);
            end
        end
    end

    // Digest beat: low lanes of the shifter, lanes past the remaining count zeroed
    always_comb begin
        hash_o = '0;
        for (int j = 0; j < DW_B; j++) begin
            if (r_state == S_HOUT && RW'(j) < r_rem)
                hash_o[8*j +: 8] = r_hash[8*j +: 8];
        end
    end

endmodule

// File: tb/tb_blake2_io_stream.sv
// Randomised bench for blake2_io_stream with a byte-level reference model.
module tb_blake2_io_stream;

    localparam int DW_B = 4, BB = 64, LL_W = 64, HASH_B = 32;
    localparam logic [1:0] CONF = 2'd0, START = 2'd1, DATA = 2'd2, LAST = 2'd3;

    logic                    clk = 1'b0, nreset = 1'b0;
    logic                    valid_i = 1'b0, block_ready_i = 1'b0, hash_v_i = 1'b0;
    logic [1:0]              cmd_i = 2'd0;
    logic [8*DW_B-1:0]       data_i = '0;
    logic [8*HASH_B-1:0]     hash_i = '0;
    logic                    ready_o, block_v_o, block_first_o, block_last_o;
    logic                    hash_v_o, hash_last_o;
    logic [7:0]              kk_o, nn_o;
    logic [LL_W-1:0]         ll_o;
    logic [8*BB-1:0]         block_o;
    logic [$clog2(BB+1)-1:0] block_bytes_o;
    logic [8*DW_B-1:0]       hash_o;

    blake2_io_stream #(.DW_B(DW_B), .BB(BB), .LL_W(LL_W), .HASH_B(HASH_B)) dut (
        .clk(clk), .nreset(nreset), .valid_i(valid_i), .ready_o(ready_o),
        .cmd_i(cmd_i), .data_i(data_i), .kk_o(kk_o), .nn_o(nn_o), .ll_o(ll_o),
        .block_v_o(block_v_o), .block_ready_i(block_ready_i), .block_o(block_o),
        .block_first_o(block_first_o), .block_last_o(block_last_o),
        .block_bytes_o(block_bytes_o), .hash_v_i(hash_v_i), .hash_i(hash_i),
        .hash_v_o(hash_v_o), .hash_o(hash_o), .hash_last_o(hash_last_o));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // reference model state
    logic [7:0]  m_kk, m_nn;
    logic [63:0] m_ll;
    int          m_cfg_cnt, m_cnt;
    bit          m_fill, m_first;
    logic [7:0]  m_buf[BB];
    int          g_hold = -1;
    bit          g_ramp = 0, g_abort = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_kk = 0; m_nn = 0; m_ll = 0; m_cfg_cnt = 0; m_cnt = 0;
        m_fill = 0; m_first = 0;
        for (int i = 0; i < BB; i++) m_buf[i] = 0;
    endtask

    task automatic cfg_byte(input logic [7:0] b);
        if (m_cfg_cnt == 0) m_kk = b;
        else if (m_cfg_cnt == 1) m_nn = b;
        else if (m_cfg_cnt < 2 + LL_W/8) m_ll = {m_ll[55:0], b};
        if (m_cfg_cnt < 2 + LL_W/8) m_cfg_cnt++;
    endtask

    task automatic hash_phase();
        logic [255:0] hv;
        logic [31:0]  e;
        int hn, nb, idx;
        repeat ($urandom_range(0, 3)) begin
            block_ready_i = $urandom_range(0, 1);
            @(negedge clk);
            chk("hwait_hv", hash_v_o, 0);
        end
        block_ready_i = 0;
        for (int i = 0; i < 32; i++) hv[8*i +: 8] = g_ramp ? 8'(i) : 8'($urandom());
        hash_i = hv; hash_v_i = 1;
        @(posedge clk); #1;
        hash_v_i = 0;
        for (int i = 0; i < 8; i++) hash_i[32*i +: 32] = $urandom();
        hn = (m_nn >= 1 && m_nn <= HASH_B) ? int'(m_nn) : HASH_B;
        nb = (hn + DW_B - 1) / DW_B;
        for (int b = 0; b < nb; b++) begin
            @(negedge clk);
            for (int j = 0; j < DW_B; j++) begin
                idx = DW_B*b + j;
                e[8*j +: 8] = (idx < hn) ? hv[8*idx +: 8] : 8'h00;
            end
            chk("hout_v", hash_v_o, 1);
            chk("hout_data", hash_o, e);
            chk("hout_last", hash_last_o, (b == nb - 1));
            if (g_abort) begin
                nreset = 0; #1;
                chk("abort_hv", hash_v_o, 0);
                chk("abort_hlast", hash_last_o, 0);
                chk("abort_nn", nn_o, 0);
                @(negedge clk);
                nreset = 1;
                model_reset();
                g_abort = 0;
                return;
            end
        end
        @(negedge clk);
        chk("hout_done_v", hash_v_o, 0);
        chk("hout_done_rdy", ready_o, 1);
    endtask

    task automatic handle_block(input bit last);
        logic [511:0] e;
        int k;
        for (int i = 0; i < BB; i++) e[8*i +: 8] = m_buf[i];
        chk("blk_v", block_v_o, 1);
        chk("blk_data", block_o, e);
        chk("blk_first", block_first_o, m_first);
        chk("blk_last", block_last_o, last);
        chk("blk_bytes", block_bytes_o, m_cnt);
        k = (g_hold >= 0) ? g_hold : $urandom_range(0, 3);
        repeat (k) begin
            valid_i = 1; cmd_i = 2'($urandom_range(0, 3)); data_i = $urandom();
            @(negedge clk);
            chk("hold_rdy", ready_o, 0);
            chk("hold_v", block_v_o, 1);
            chk("hold_data", block_o, e);
        end
        block_ready_i = 1;
        @(posedge clk); #1;
        block_ready_i = 0; valid_i = 0;
        @(negedge clk);
        chk("rel_v", block_v_o, 0);
        m_first = 0;
        if (last) begin
            m_fill = 0;
            hash_phase();
        end else begin
            chk("rel_rdy", ready_o, 1);
            m_cnt = 0;
            for (int i = 0; i < BB; i++) m_buf[i] = 0;
        end
    endtask

    task automatic send_beat(input logic [1:0] cmd, input logic [31:0] data);
        bit closed = 0;
        valid_i = 1; cmd_i = cmd; data_i = data;
        chk("in_rdy", ready_o, 1);
        @(posedge clk); #1;
        valid_i = 0;
        if (cmd == CONF) begin
            for (int j = 0; j < DW_B; j++) cfg_byte(data[8*j +: 8]);
        end else begin
            m_cfg_cnt = 0;
            if (cmd == START) begin
                m_fill = 1; m_first = 1; m_cnt = 0;
                for (int i = 0; i < BB; i++) m_buf[i] = 0;
            end
            if (m_fill) begin
                for (int j = 0; j < DW_B; j++) m_buf[m_cnt + j] = data[8*j +: 8];
                m_cnt += DW_B;
                closed = (m_cnt == BB) || (cmd == LAST);
            end
        end
        @(negedge clk);
        chk("kk", kk_o, m_kk);
        chk("nn", nn_o, m_nn);
        chk("ll", ll_o, m_ll);
        if (closed) handle_block(cmd == LAST);
        else chk("blk_v_open", block_v_o, 0);
    endtask

    task automatic run_msg(input int ndata);
        send_beat(START, $urandom());
        repeat (ndata) send_beat(DATA, $urandom());
        send_beat(LAST, $urandom());
    endtask

    task automatic send_cfg(input logic [7:0] nn);
        logic [7:0] cb[12];
        for (int i = 0; i < 12; i++) cb[i] = 8'($urandom());
        cb[1] = nn;
        for (int b = 0; b < 3; b++)
            send_beat(CONF, {cb[4*b+3], cb[4*b+2], cb[4*b+1], cb[4*b]});
    endtask

    initial begin
        int r, nd;
        logic [7:0] nn;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_blk_v", block_v_o, 0);
        chk("rst_hash_v", hash_v_o, 0);
        chk("rst_block", block_o, 0);
        chk("rst_kk", kk_o, 0);
        chk("rst_ll", ll_o, 0);
        nreset = 1;
        @(negedge clk);
        chk("rst_rdy", ready_o, 1);

        // directed configuration: kk=0, nn=0x20, ll=3, trailing bytes ignored
        send_beat(CONF, 32'h0000_2000);
        send_beat(CONF, 32'h0000_0000);
        send_beat(CONF, 32'hEEFF_0300);
        chk("cfg_kk_const", kk_o, 8'h00);
        chk("cfg_nn_const", nn_o, 8'h20);
        chk("cfg_ll_const", ll_o, 64'd3);

        // short two-beat message
        send_beat(START, 32'h6463_6261);
        send_beat(LAST, 32'h6867_6665);

        // nn=20, long hold, ramp digest; 68 bytes -> full block then LAST-only block
        send_cfg(8'd20);
        g_hold = 10; g_ramp = 1;
        run_msg(15);
        g_hold = -1; g_ramp = 0;

        // LAST exactly filling a block
        run_msg(14);

        // restart after 12 bytes, DATA dropped in IDLE beforehand
        send_beat(DATA, $urandom());
        send_beat(START, $urandom());
        send_beat(DATA, $urandom());
        send_beat(DATA, $urandom());
        send_beat(START, 32'hA5A5_0102);
        send_beat(DATA, $urandom());
        send_beat(LAST, $urandom());

        // randomised messages
        for (int m = 0; m < 25; m++) begin
            if ($urandom_range(0, 3) == 0) send_beat(2'($urandom_range(2, 3)), $urandom());
            r = $urandom_range(0, 3);
            nn = (r == 0) ? 8'd0 : (r == 1) ? 8'($urandom_range(33, 255)) : 8'($urandom_range(1, 32));
            send_cfg(nn);
            send_beat(START, $urandom());
            nd = $urandom_range(0, 40);
            for (int i = 0; i < nd; i++) begin
                r = $urandom_range(0, 29);
                if (r == 0) send_beat(START, $urandom());
                else if (r == 1) send_beat(CONF, $urandom());
                else send_beat(DATA, $urandom());
            end
            send_beat(LAST, $urandom());
        end

        // reset in the middle of a block
        send_beat(START, $urandom());
        send_beat(DATA, $urandom());
        nreset = 0; #1;
        chk("midblk_block", block_o, 0);
        chk("midblk_bytes", block_bytes_o, 0);
        @(negedge clk);
        nreset = 1;
        model_reset();
        run_msg(3);

        // reset during digest output
        send_cfg(8'd20);
        g_abort = 1;
        run_msg(2);
        @(negedge clk);
        chk("post_abort_rdy", ready_o, 1);
        run_msg(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
